// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary decoder: five digits, MSD first, one Horner step per cycle.
// Optional macro BCD2BIN_CHECK_EN enables invalid-digit detection (bin forced to 0, err set).
module bcd2bin_seq (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  BCD_0,
   input  logic [3:0]  BCD_1,
   input  logic [3:0]  BCD_2,
   input  logic [3:0]  BCD_3,
   input  logic [3:0]  BCD_4,
   output logic [16:0] bin,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // Handshake: start is sampled only while idle (busy=0); starts during busy are
   // dropped. done pulses for one cycle when bin/err are updated; busy falls with it.
   typedef enum logic {IDLE, CONV} state_t;

   state_t      state;
   logic [19:0] digits;
   logic [16:0] acc;
   logic [2:0]  idx;
   logic [3:0]  cur_digit;
   logic [16:0] mac;

   always_comb begin
      cur_digit = 4'd0;
      case (idx)
         3'd0:    cur_digit = digits[3:0];
         3'd1:    cur_digit = digits[7:4];
         3'd2:    cur_digit = digits[11:8];
         3'd3:    cur_digit = digits[15:12];
         3'd4:    cur_digit = digits[19:16];
         default: cur_digit = 4'd0;
      endcase
   end

   // acc*10 as two shifts; everything stays 17 bits so the result wraps mod 2^17
   assign mac = (acc << 3) + (acc << 1) + {13'd0, cur_digit};

`ifdef BCD2BIN_CHECK_EN
   logic invalid;
   logic any_bad;

   assign any_bad = (BCD_0 > 4'd9) | (BCD_1 > 4'd9) | (BCD_2 > 4'd9) |
                    (BCD_3 > 4'd9) | (BCD_4 > 4'd9);
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state  <= IDLE;
         digits <= 20'd0;
         acc    <= 17'd0;
         idx    <= 3'd4;
         bin    <= 17'd0;
         busy   <= 1'b0;
         done   <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
         invalid <= 1'b0;
         err     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  digits <= {BCD_4, BCD_3, BCD_2, BCD_1, BCD_0};
                  acc    <= 17'd0;
                  idx    <= 3'd4;
                  busy   <= 1'b1;
                  state  <= CONV;
`ifdef BCD2BIN_CHECK_EN
                  invalid <= any_bad;
`endif
               end
            end
            CONV: begin
               acc <= mac;
               idx <= idx - 3'd1;
               if (idx == 3'd0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
                  idx   <= 3'd4;
`ifdef BCD2BIN_CHECK_EN
                  bin <= invalid ? 17'd0 : mac;
                  err <= invalid;
`else
                  bin <= mac;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: vector table, hand-written handshake/reset
// sequences and randomized conversions checked against a positional-weight model.
module tb_bcd2bin_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  bcd [5];
   logic [16:0] bin;
   logic        busy;
   logic        done;
   logic        err;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;

   logic [17:0] exp_q[$];

   typedef struct {
      logic [19:0] digs;
      logic [16:0] exp_bin;
      logic        exp_err;
   } vec_t;

   bcd2bin_seq dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .start    (start),
      .BCD_0    (bcd[0]),
      .BCD_1    (bcd[1]),
      .BCD_2    (bcd[2]),
      .BCD_3    (bcd[3]),
      .BCD_4    (bcd[4]),
      .bin      (bin),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   // clock / reset
   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // reference: plain positional decimal value, wrapped mod 2^17; returns {err, bin}
   function automatic logic [17:0] model(input logic [19:0] d);
      int unsigned weight [5] = '{1, 10, 100, 1000, 10000};
      int unsigned v = 0;
      bit bad = 0;
      for (int i = 0; i < 5; i++) begin
         int unsigned dig = 32'(d[i*4 +: 4]);
         v += dig * weight[i];
         if (dig > 9) bad = 1;
      end
      v = v % 131072;
`ifdef BCD2BIN_CHECK_EN
      if (bad) return {1'b1, 17'd0};
`endif
      return {1'b0, v[16:0]};
   endfunction

   // driver
   task automatic set_digits(input logic [19:0] d);
      for (int i = 0; i < 5; i++) bcd[i] = d[i*4 +: 4];
   endtask

   // Full conversion: start accepted at edge k, done exactly after edge k+5, gone at k+6.
   task automatic run_conv(input string name, input logic [19:0] d, input logic [17:0] exp);
      logic [17:0] e;
      exp_q.push_back(exp);
      set_digits(d);
      start = 1'b1;
      wait_edges(1);
      start = 1'b0;
      check({name, "_busy_start"}, {31'd0, busy}, 32'd1);
      for (int c = 1; c <= 4; c++) begin
         wait_edges(1);
         if (done) check({name, "_early_done"}, {31'd0, done}, 32'd0);
      end
      wait_edges(1);
      e = exp_q.pop_front();
      check({name, "_done"}, {31'd0, done}, 32'd1);
      check({name, "_busy_end"}, {31'd0, busy}, 32'd0);
      check({name, "_bin"}, {15'd0, bin}, {15'd0, e[16:0]});
      check({name, "_err"}, {31'd0, err}, {31'd0, e[17]});
      wait_edges(1);
      check({name, "_done_drop"}, {31'd0, done}, 32'd0);
   endtask

   vec_t vecs [6];

   initial begin
      int base;
      logic [19:0] d;

      vecs[0] = '{20'h12345, 17'd12345, 1'b0};
      vecs[1] = '{20'h99999, 17'd99999, 1'b0};
      vecs[2] = '{20'h00000, 17'd0, 1'b0};
      vecs[3] = '{20'h00042, 17'd42, 1'b0};
`ifdef BCD2BIN_CHECK_EN
      vecs[4] = '{20'h00A00, 17'd0, 1'b1};
      vecs[5] = '{20'hFFFFF, 17'd0, 1'b1};
`else
      vecs[4] = '{20'h00A00, 17'd1000, 1'b0};
      vecs[5] = '{20'hFFFFF, 17'd35593, 1'b0};
`endif

      reset = 1'b1;
      start = 1'b0;
      set_digits(20'h0);
      wait_edges(2);
      reset = 1'b0;
      check("rst_bin", {15'd0, bin}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);

      for (int i = 0; i < 6; i++)
         run_conv($sformatf("vec%0d", i), vecs[i].digs, {vecs[i].exp_err, vecs[i].exp_bin});

      // handshake: digit change and extra start during busy, then back-to-back start
      base = done_cnt;
      set_digits(20'h00042);
      start = 1'b1;
      wait_edges(1);
      start = 1'b0;
      wait_edges(1);
      set_digits(20'h77777);
      start = 1'b1;
      wait_edges(1);
      start = 1'b0;
      wait_edges(3);
      check("hs_done", {31'd0, done}, 32'd1);
      check("hs_bin", {15'd0, bin}, 32'd42);
      set_digits(20'h00007);
      start = 1'b1;
      wait_edges(1);
      start = 1'b0;
      check("hs_one_done", done_cnt - base, 32'd1);
      check("hs_b2b_busy", {31'd0, busy}, 32'd1);
      wait_edges(4);
      check("hs_b2b_early", {31'd0, done}, 32'd0);
      wait_edges(1);
      check("hs_b2b_done", {31'd0, done}, 32'd1);
      check("hs_b2b_bin", {15'd0, bin}, 32'd7);
      wait_edges(1);
      check("hs_total_done", done_cnt - base, 32'd2);

      // reset mid-conversion
      set_digits(20'h54321);
      start = 1'b1;
      wait_edges(1);
      start = 1'b0;
      wait_edges(2);
      reset = 1'b1;
      base = done_cnt;
      wait_edges(1);
      reset = 1'b0;
      check("mid_rst_bin", {15'd0, bin}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      wait_edges(6);
      check("mid_rst_no_done", done_cnt - base, 32'd0);
      run_conv("post_rst", 20'h54321, 18'd54321);

      // randomized conversions with random idle gaps
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 5; i++)
            d[i*4 +: 4] = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9))
                                                     : 4'($urandom_range(0, 15));
         run_conv($sformatf("rnd%0d", n), d, model(d));
         wait_edges($urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
